fetch_unit: RTL



---
 rtl/fetch_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Purpose : instruction fetch sequencer between PC register, instruction memory and decode.
// Latency : request handshake in cycle N, response in N+k, instruction visible in N+k+1.
// Backpres: one outstanding request; a new request issues only when the 1-entry buffer
//           is empty or draining. A taken redirect flushes the buffer and drops a stale response.
//
// Ports:
//   clk, reset                  core clock, asynchronous active-high reset
//   pc / pc_next                current PC in, next PC out (PC register captures every clock)
//   imem_req_*                  fetch request (valid/ready), address always equals pc
//   imem_rsp_*                  response pulse, one per accepted request
//   redirect_valid/_target      branch/jump redirect from execute (single-cycle pulse)
//   inst_valid/_ready/_data/_pc 1-entry output buffer toward decode
module fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] inst_data_q,  inst_data_d;
    logic [ADDR_W-1:0] inst_pc_q,    inst_pc_d;

    logic              req_vld;
    logic              rsp_accept;
    logic              can_issue;
    logic [ADDR_W-1:0] redirect_pc;

    // Instructions are word aligned; low address bits of a redirect are ignored.
    assign redirect_pc = {redirect_target[ADDR_W-1:2], 2'b00};

    // Buffer has room this cycle if empty or being consumed by decode.
    assign can_issue = !inst_valid_q || inst_ready;

    // ------------------------------------------------------------------
    // Next-state and control
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        req_vld    = 1'b0;
        rsp_accept = 1'b0;

        case (state_q)
            S_REQ: begin
                // A redirect suppresses the request: pc is stale this cycle.
                req_vld = !reset && !redirect_valid && can_issue;
                if (req_vld && imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d    = S_REQ;
                    // A response coinciding with a redirect belongs to the
                    // wrong path and is thrown away.
                    rsp_accept = !redirect_valid;
                end else if (redirect_valid) begin
                    // Response still in flight; remember to discard it.
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    always_comb begin
        inst_valid_d = inst_valid_q;
        inst_data_d  = inst_data_q;
        inst_pc_d    = inst_pc_q;

        if (redirect_valid) begin
            // Flush wins over a same-cycle drain.
            inst_valid_d = 1'b0;
        end else if (rsp_accept) begin
            // Load (possibly together with a drain of the old entry).
            inst_valid_d = 1'b1;
            inst_data_d  = imem_rsp_data;
            inst_pc_d    = pc;
        end else if (inst_valid_q && inst_ready) begin
            inst_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next PC: redirect > sequential advance on accepted response > hold
    // ------------------------------------------------------------------
    always_comb begin
        pc_next = pc;
        if (reset) begin
            pc_next = pc;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (rsp_accept) begin
            pc_next = pc + ADDR_W'(4);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_REQ;
            inst_valid_q <= 1'b0;
            inst_data_q  <= '0;
            inst_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    assign imem_req_valid = req_vld;
    assign imem_req_addr  = pc;
    assign inst_valid     = inst_valid_q;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;

endmodule
